// File: rtl/flash_burst_reader.sv
// Burst master for the SPI flash read wrapper: fetches a run of bytes through the byte-wide
// valid/ready read port and streams them out as little-endian 32-bit words.
module flash_burst_reader #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       out_data_o,
   output logic [3:0]        out_keep_o,
   output logic              out_last_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_GAP,
      S_PUSH,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  rem_q;
   logic [2:0]        byte_cnt_q;
   logic [31:0]       data_q;
   logic [3:0]        keep_q;
   logic              last_q;

   logic take_start;
   logic take_byte;
   logic take_word;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      take_start = 1'b0;
      take_byte  = 1'b0;
      take_word  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  take_start = 1'b1;
                  state_d    = S_REQ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_REQ: begin
            if (mem_ready_i) begin
               take_byte = 1'b1;
               state_d   = S_GAP;
            end
         end
         // One idle cycle so the wrapper always sees valid drop between reads.
         S_GAP: begin
            if (byte_cnt_q == 3'd4 || rem_q == '0) begin
               state_d = S_PUSH;
            end else begin
               state_d = S_REQ;
            end
         end
         S_PUSH: begin
            if (out_ready_i) begin
               take_word = 1'b1;
               state_d   = (rem_q == '0) ? S_DONE : S_REQ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         mem_valid_o <= 1'b0;
         out_valid_o <= 1'b0;
         addr_q      <= '0;
         rem_q       <= '0;
         byte_cnt_q  <= '0;
         data_q      <= '0;
         keep_q      <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_o      <= (state_d == S_REQ) || (state_d == S_GAP) || (state_d == S_PUSH);
         done_o      <= (state_d == S_DONE);
         mem_valid_o <= (state_d == S_REQ);
         out_valid_o <= (state_d == S_PUSH);

         if (take_start) begin
            addr_q     <= base_addr_i;
            rem_q      <= len_i;
            byte_cnt_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
         end

         // Lanes fill in order, so keep_q always equals (1 << byte_cnt) - 1.
         if (take_byte) begin
            data_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= mem_rdata_i;
            keep_q[byte_cnt_q[1:0]]                <= 1'b1;
            byte_cnt_q                             <= byte_cnt_q + 3'd1;
            addr_q                                 <= addr_q + ADDR_W'(1);
            rem_q                                  <= rem_q - LEN_W'(1);
         end

         if (state_q == S_GAP) begin
            last_q <= (rem_q == '0);
         end

         if (take_word) begin
            byte_cnt_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
         end
      end
   end

   assign mem_addr_o = addr_q;
   assign out_data_o = data_q;
   assign out_keep_o = keep_q;
   assign out_last_o = last_q;

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader: flash model (byte = addr[7:0], 3-cycle latency),
// address and word scoreboards, stall, wrap, zero-length and mid-burst reset scenarios.
module tb_flash_burst_reader;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic [23:0] base_addr_i;
   logic [15:0] len_i;
   logic        busy_o;
   logic        done_o;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [23:0] mem_addr_o;
   logic [7:0]  mem_rdata_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic [3:0]  out_keep_o;
   logic        out_last_o;

   int n_checks = 0;
   int n_fail   = 0;
   int done_hi  = 0;
   int mv_cycles = 0;
   int ov_cycles = 0;
   logic flash_en = 1'b1;

   word_t       exp_words[$];
   logic [23:0] exp_addrs[$];

   flash_burst_reader #(.ADDR_W(24), .LEN_W(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .mem_addr_o  (mem_addr_o),
      .mem_rdata_i (mem_rdata_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_keep_o  (out_keep_o),
      .out_last_o  (out_last_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected words and request addresses for a burst, built byte by byte.
   task automatic expect_burst(input logic [23:0] base, input int len);
      word_t w;
      int    lane;
      logic [23:0] a;
      w    = '0;
      lane = 0;
      for (int i = 0; i < len; i++) begin
         a = base + 24'(i);
         exp_addrs.push_back(a);
         w.data[lane*8 +: 8] = a[7:0];
         w.keep[lane] = 1'b1;
         lane++;
         if (lane == 4 || i == len - 1) begin
            w.last = (i == len - 1);
            exp_words.push_back(w);
            w    = '0;
            lane = 0;
         end
      end
   endtask

   task automatic start_burst(input logic [23:0] base, input logic [15:0] len);
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = base;
      len_i       = len;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int n;
      d0 = done_hi;
      n  = 0;
      while (done_hi == d0 && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("done_seen", done_hi - d0, 1);
      repeat (4) @(negedge clk);
      #2;
      check("done_once", done_hi - d0, 1);
      check("words_drained", exp_words.size(), 0);
      check("reqs_drained", exp_addrs.size(), 0);
      check("idle_busy", busy_o, 0);
   endtask

   // Flash model: ready pulse 3 cycles after valid, data = addr[7:0].
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!flash_en) begin
            cnt = 0;
         end else if (rst_i) begin
            cnt = 0;
            mem_ready_i = 1'b0;
         end else if (mem_ready_i) begin
            mem_ready_i = 1'b0;
            cnt = 0;
         end else if (mem_valid_o) begin
            cnt++;
            if (cnt == 3) begin
               mem_ready_i = 1'b1;
               mem_rdata_i = mem_addr_o[7:0];
               cnt = 0;
               if (exp_addrs.size() == 0) begin
                  check("req_pending", exp_addrs.size(), 1);
               end else begin
                  check("req_addr", 32'(mem_addr_o), 32'(exp_addrs.pop_front()));
               end
            end
         end
      end
   end

   // Output monitor and scoreboard.
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         #1;
         if (done_o) done_hi++;
         if (mem_valid_o) mv_cycles++;
         if (out_valid_o) begin
            ov_cycles++;
            check("no_req_during_push", 32'(mem_valid_o), 0);
            if (out_ready_i) begin
               if (exp_words.size() == 0) begin
                  check("word_pending", exp_words.size(), 1);
               end else begin
                  e = exp_words.pop_front();
                  check("word_data", out_data_o, e.data);
                  check("word_keep", 32'(out_keep_o), 32'(e.keep));
                  check("word_last", 32'(out_last_o), 32'(e.last));
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int mv0;
      int ov0;
      int n;
      logic [31:0] held_data;
      logic [3:0]  held_keep;

      rst_i       = 1'b1;
      start_i     = 1'b0;
      base_addr_i = '0;
      len_i       = '0;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      out_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_mem_valid", mem_valid_o, 0);
      check("rst_mem_addr", 32'(mem_addr_o), 0);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_out_keep", 32'(out_keep_o), 0);
      check("rst_out_last", out_last_o, 0);
      rst_i = 1'b0;

      // Two full words from 0x100000.
      expect_burst(24'h100000, 8);
      start_burst(24'h100000, 16'd8);
      check("busy_after_start", busy_o, 1);
      wait_done(400);

      // Partial trailing word.
      expect_burst(24'h000010, 5);
      start_burst(24'h000010, 16'd5);
      wait_done(400);

      // Zero length: done only, no traffic.
      mv0 = mv_cycles;
      ov0 = ov_cycles;
      @(negedge clk);
      start_i = 1'b1;
      len_i   = '0;
      base_addr_i = 24'h123456;
      lat = 0;
      n   = 0;
      while (lat == 0 && n < 5) begin
         @(negedge clk);
         start_i = 1'b0;
         #2;
         n++;
         if (done_o) lat = n;
      end
      check("len0_done_seen", 32'(lat != 0), 1);
      check("len0_done_latency_ok", 32'(lat <= 2), 1);
      @(negedge clk);
      #2;
      check("len0_done_width", done_o, 0);
      repeat (3) @(negedge clk);
      check("len0_no_mem_valid", mv_cycles - mv0, 0);
      check("len0_no_out_valid", ov_cycles - ov0, 0);

      // Backpressure on the first word.
      expect_burst(24'h100000, 8);
      out_ready_i = 1'b0;
      start_burst(24'h100000, 16'd8);
      n = 0;
      while (!out_valid_o && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("stall_word_seen", out_valid_o, 1);
      held_data = out_data_o;
      held_keep = out_keep_o;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #2;
         check("stall_valid", out_valid_o, 1);
         check("stall_data", out_data_o, held_data);
         check("stall_keep", 32'(out_keep_o), 32'(held_keep));
         check("stall_mem_idle", mem_valid_o, 0);
      end
      @(negedge clk);
      out_ready_i = 1'b1;
      wait_done(400);

      // Address wrap.
      expect_burst(24'hFFFFFE, 4);
      start_burst(24'hFFFFFE, 16'd4);
      wait_done(400);

      // Reset mid-request, then a stale completion.
      start_burst(24'h000020, 16'd8);
      n = 0;
      while (!mem_valid_o && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("abort_valid_seen", mem_valid_o, 1);
      flash_en    = 1'b0;
      mem_ready_i = 1'b0;
      rst_i       = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("abort_busy", busy_o, 0);
      check("abort_mem_valid", mem_valid_o, 0);
      check("abort_out_valid", out_valid_o, 0);
      check("abort_done", done_o, 0);
      check("abort_addr", 32'(mem_addr_o), 0);
      rst_i       = 1'b0;
      mem_ready_i = 1'b1;
      mem_rdata_i = 8'hAA;
      @(negedge clk);
      mem_ready_i = 1'b0;
      #2;
      check("stale_ready_mem_valid", mem_valid_o, 0);
      check("stale_ready_busy", busy_o, 0);
      check("stale_ready_out_valid", out_valid_o, 0);
      repeat (2) @(negedge clk);
      #2;
      check("stale_ready_done", done_o, 0);
      check("stale_ready_out_data", out_data_o, 0);
      flash_en = 1'b1;

      expect_burst(24'h000000, 4);
      start_burst(24'h000000, 16'd4);
      wait_done(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
